lsu_mem_unit: RTL and testbench
===============================

# lsu_mem_unit

Parametrised load/store unit between the core's execute stage and the data-memory port. It replaces the fixed 64-bit, store-only, single-cycle memory path with a handshaked, multi-cycle unit. The unit supports byte/half/word/double accesses, sign or zero extension on loads, and byte-masked stores. It also provides misalignment detection and a response timeout.

## Interface
Parameters:
- `XLEN`, 64, data width; legal values are 32 and 64.
- `ADDR_W`, 64, address width.
- `TIMEOUT`, 255, maximum number of cycles spent in WAIT before an error response; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned`  in  1  zero-extend the load result (LBU/LHU/LWU).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  core accepts the response.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal size, or timeout.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_W  request address with the low log2(XLEN/8) bits forced to 0.
- `mem_wdata`  out  XLEN  store data shifted into its byte lanes.
- `mem_wmask`  out  XLEN/8  byte-lane enables.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  XLEN  full aligned read word.

## Operation
FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch we/size/unsigned/addr/wdata.
  - If the request is illegal, go to RESP with err = 1. Illegal means misaligned (addr mod 2^size ≠ 0) or size = 3 with XLEN = 32.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req_valid` = 1, and mem_* outputs are held stable until `mem_req_ready`.
  - On acceptance: a store goes to RESP (the store completes at acceptance); a load goes to WAIT and clears the timeout counter.
- **WAIT**
  - On `mem_rvalid`, capture the extracted data and go to RESP with err = 0.
  - Otherwise the counter increments. When counter = TIMEOUT (TIMEOUT ≠ 0), go to RESP with err = 1 and rdata = 0.
  - If `mem_rvalid` arrives in the same cycle the counter reaches TIMEOUT, the data wins.
- **RESP**
  - `resp_valid` = 1, and `resp_rdata`/`resp_err` are held until `resp_ready`, then go to IDLE.
  - No new request is accepted in the same cycle as the RESP handshake.

Lane rules (off = addr low bits, in bytes):
- `mem_wmask` = ((1 << 2^size) − 1) << off.
- `mem_wdata` = wdata << (8·off); unused lanes carry the shifted value and are masked.
- Load: data = mem_rdata >> (8·off), truncated to 8·2^size bits, then sign-extended to XLEN unless `req_unsigned`.
- size 2 on XLEN = 32 ignores `req_unsigned`.

Other rules:
- `mem_rvalid` outside WAIT is ignored.
- A stray or late response after a timeout is dropped.

## Timing
Reset:
- The state is IDLE.
- `req_ready` = 0 while `rst_n` = 0, and 1 from the first cycle after release.
- `resp_valid`, `resp_err`, `mem_req_valid` and `mem_we` are 0; `resp_rdata`, `mem_addr`, `mem_wdata` and `mem_wmask` are all 0.
- The counter is 0.

Cycle 0 below is the cycle in which the request is accepted.

Latency with zero-wait memory:
- Illegal request: `resp_valid` in cycle 1.
- Store: `mem_req_valid` in cycle 1, `resp_valid` in cycle 2.
- Load: `mem_req_valid` in cycle 1, `mem_rvalid` earliest in cycle 2, `resp_valid` in cycle 3.

Throughput: one access per 3 cycles (store) or 4 cycles (load) minimum.

Outputs:
- All mem_* and resp_* outputs are registered or decoded from state and latched registers only.
- There is no combinational path from any input to any output, except `req_ready` from `rst_n`.

Reset mid-operation:
- Asserting `rst_n` = 0 in any state abandons the access.
- `mem_req_valid` and `resp_valid` drop immediately (asynchronously).
- A `mem_rvalid` arriving after reset release is ignored.

## Test plan
- **Aligned byte load, sign extension:** XLEN = 64, load addr 0x8000_0003, size 0, signed; mem_rdata = 0x1122_3344_8566_7788.
  - `mem_addr` = 0x8000_0000.
  - `resp_rdata` = 0xFFFF_FFFF_FFFF_FF85 in cycle 3.
- **Half store, lane placement:** store addr 0x8000_0006, size 1, wdata 0xBEEF.
  - `mem_wmask` = 0xC0, `mem_wdata`[63:48] = 0xBEEF.
  - `resp_valid` in cycle 2, `resp_err` = 0.
- **Misaligned word:** load addr 0x8000_0002, size 2.
  - `mem_req_valid` is never asserted.
  - `resp_valid` = 1 and `resp_err` = 1 in cycle 1.
- **Backpressure:** hold `mem_req_ready` = 0 for 5 cycles, then hold `resp_ready` = 0 for 3 cycles.
  - mem_* outputs stay stable through the stall.
  - `resp_rdata` stays stable through the stall.
  - `req_ready` = 0 throughout.
- **Timeout:** TIMEOUT = 4, load with no `mem_rvalid`.
  - `resp_err` = 1 and `resp_rdata` = 0 after 4 WAIT cycles.
  - A later `mem_rvalid` is ignored; the next load completes normally.
- **XLEN = 32 configuration and async reset:** with XLEN = 32, a size-3 request gives `resp_err` = 1. An LW of 0x8000_1234 returns it unextended. Asserting `rst_n` = 0 during WAIT gives IDLE, all outputs 0, and a subsequent `mem_rvalid` is dropped.

Source files
------------

// File: rtl/lsu_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_unit
// Brief    : Handshaked multi-cycle load/store unit between execute stage and
//            the data-memory port. B/H/W/D accesses, sign/zero-extending
//            loads, byte-masked stores, misalignment check, WAIT timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_unit #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int c_nb    = XLEN / 8;
  localparam int c_off_w = $clog2(c_nb);
  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
  localparam bit c_to_en  = (TIMEOUT != 0);
  localparam bit c_has_d  = (XLEN == 64);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_req  = 2'd1;
  localparam logic [1:0] c_wait = 2'd2;
  localparam logic [1:0] c_resp = 2'd3;

  logic [1:0]         r_state;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [c_off_w-1:0] r_off;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [XLEN-1:0]    r_mem_wdata;
  logic [c_nb-1:0]    r_mem_wmask;
  logic [XLEN-1:0]    r_rdata;
  logic               r_err;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_misaligned;
  logic               w_illegal;
  logic [7:0]         w_len_mask;
  logic [c_nb-1:0]    w_wmask;
  logic [XLEN-1:0]    w_shifted;
  logic [XLEN-1:0]    w_load;
  logic [c_cnt_w-1:0] w_cnt_next;

  // Request legality and store byte-lane mask, decoded from the incoming request
  always_comb begin
    w_misaligned = 1'b0;
    w_len_mask   = 8'h00;
    case (req_size)
      2'd0: begin w_misaligned = 1'b0;             w_len_mask = 8'h01; end
      2'd1: begin w_misaligned = req_addr[0];      w_len_mask = 8'h03; end
      2'd2: begin w_misaligned = |req_addr[1:0];   w_len_mask = 8'h0F; end
      default: begin w_misaligned = |req_addr[2:0]; w_len_mask = 8'hFF; end
    endcase
    // A doubleword request is only legal when the datapath is 64 bits wide
    w_illegal = w_misaligned | ((req_size == 2'd3) & ~c_has_d);
    w_wmask   = c_nb'(w_len_mask) << req_addr[c_off_w-1:0];
  end

  // Load data extraction: shift the addressed lane down, then truncate and extend
  always_comb begin
    w_shifted = mem_rdata >> {r_off, 3'b000};
    w_load    = w_shifted;
    case (r_size)
      2'd0: w_load = r_unsigned ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
      2'd1: w_load = r_unsigned ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
      // On a 32-bit datapath both arms are identical, so req_unsigned has no effect
      2'd2: w_load = r_unsigned ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
      default: w_load = w_shifted;
    endcase
    w_cnt_next = r_cnt + c_cnt_w'(1);
  end

  // Control FSM with latched request fields and registered memory/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_off       <= req_addr[c_off_w-1:0];
            r_mem_addr  <= {req_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
            r_mem_wdata <= req_wdata << {req_addr[c_off_w-1:0], 3'b000};
            r_mem_wmask <= w_wmask;
            r_rdata     <= '0;
            r_err       <= w_illegal;
            r_state     <= w_illegal ? c_resp : c_req;
          end
        end
        c_req: begin
          if (mem_req_ready) begin
            // A store is complete once the memory accepts it
            if (r_we) begin
              r_state <= c_resp;
            end else begin
              r_cnt   <= '0;
              r_state <= c_wait;
            end
          end
        end
        c_wait: begin
          // Data arriving on the timeout cycle still wins
          if (mem_rvalid) begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
            r_state <= c_resp;
          end else begin
            r_cnt <= w_cnt_next;
            if (c_to_en && (w_cnt_next == c_timeout)) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_state <= c_resp;
            end
          end
        end
        c_resp: begin
          if (resp_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Handshake outputs decoded from state so they drop with an asynchronous reset
  assign req_ready     = rst_n & (r_state == c_idle);
  assign mem_req_valid = (r_state == c_req);
  assign mem_we        = (r_state == c_req) & r_we;
  assign resp_valid    = (r_state == c_resp);
  assign resp_rdata    = r_rdata;
  assign resp_err      = r_err;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = r_mem_wmask;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_unit
// Brief    : Self-checking bench for lsu_mem_unit. One 64-bit unit (TIMEOUT=4)
//            and one 32-bit unit share stimulus; sel32 picks the unit under
//            observation. Expected values come from an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned, resp_ready, mem_req_ready, mem_rvalid;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  bit          sel32;
  int          total = 0;
  int          bad   = 0;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_we;
  logic [63:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [7:0]  a_mem_wmask;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_we;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wmask;

  logic        req_ready, resp_valid, resp_err, mem_req_valid, mem_we;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  lsu_mem_unit #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4)) u64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel32), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wmask(a_mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_mem_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(255)) u32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel32), .req_ready(b_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
  );

  assign req_ready     = sel32 ? b_req_ready     : a_req_ready;
  assign resp_valid    = sel32 ? b_resp_valid    : a_resp_valid;
  assign resp_err      = sel32 ? b_resp_err      : a_resp_err;
  assign mem_req_valid = sel32 ? b_mem_req_valid : a_mem_req_valid;
  assign mem_we        = sel32 ? b_mem_we        : a_mem_we;
  assign resp_rdata    = sel32 ? {32'h0, b_resp_rdata} : a_resp_rdata;
  assign mem_addr      = sel32 ? {32'h0, b_mem_addr}   : a_mem_addr;
  assign mem_wdata     = sel32 ? {32'h0, b_mem_wdata}  : a_mem_wdata;
  assign mem_wmask     = sel32 ? {4'h0, b_mem_wmask}   : a_mem_wmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load result: pick the addressed bytes and extend them
  function automatic logic [63:0] ref_load(input int xl, input logic [63:0] rd,
                                           input logic [1:0] size, input bit uns, input int off);
    logic [63:0] v, m;
    int nb;
    nb = 8 << size;
    v  = ((xl == 32) ? (rd & 64'hFFFF_FFFF) : rd) >> (8 * off);
    m  = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v  = v & m;
    if (!uns && nb < xl && v[nb-1]) v = v | ~m;
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One complete access with optional memory-side and response-side stalls
  task automatic xact(input bit we, input logic [1:0] size, input bit uns,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] rdata, input int mstall, input int rstall);
    int xl, off;
    bit ill;
    logic [63:0] xm, e_maddr, e_wd, e_rd;
    logic [7:0] e_mask;
    xl      = sel32 ? 32 : 64;
    xm      = sel32 ? 64'hFFFF_FFFF : '1;
    off     = int'(addr % 64'(xl / 8));
    ill     = ((addr % (64'd1 << size)) != 0) || (size == 2'd3 && xl == 32);
    e_maddr = addr & xm & ~64'(xl / 8 - 1);
    e_mask  = 8'(((1 << (1 << size)) - 1) << off);
    e_wd    = ((wdata & xm) << (8 * off)) & xm;
    e_rd    = (we || ill) ? 64'h0 : ref_load(xl, rdata, size, uns, off);
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (ill) begin
      chk("ill_mem_req_valid", mem_req_valid, 0);
      chk("ill_resp_valid", resp_valid, 1);
      chk("ill_resp_err", resp_err, 1);
      chk("ill_resp_rdata", resp_rdata, 0);
    end else begin
      for (int i = 0; i <= mstall; i++) begin
        chk("req_mem_req_valid", mem_req_valid, 1);
        chk("req_mem_addr", mem_addr, e_maddr);
        chk("req_mem_we", mem_we, 64'(we));
        chk("req_req_ready", req_ready, 0);
        if (we) begin
          chk("req_mem_wmask", mem_wmask, e_mask);
          chk("req_mem_wdata", mem_wdata, e_wd);
        end
        mem_req_ready = (i == mstall);
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      chk("post_req_mem_req_valid", mem_req_valid, 0);
      if (!we) begin
        chk("wait_resp_valid", resp_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
      end
      chk("resp_valid", resp_valid, 1);
      chk("resp_err", resp_err, 0);
      chk("resp_rdata", resp_rdata, e_rd);
    end
    for (int i = 0; i < rstall; i++) begin
      @(negedge clk);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_rdata", resp_rdata, e_rd);
      chk("stall_resp_err", resp_err, 64'(ill));
      chk("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("after_resp_valid", resp_valid, 0);
    chk("after_req_ready", req_ready, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; sel32 = 1'b0;

    // Reset state of both units
    repeat (2) @(negedge clk);
    chk_all_zero("rst64");
    sel32 = 1'b1; #1;
    chk_all_zero("rst32");
    sel32 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);

    // Directed cases on the 64-bit unit
    xact(0, 2'd0, 0, 64'h8000_0003, 64'h0, 64'h1122_3344_8566_7788, 0, 0);
    xact(1, 2'd1, 0, 64'h8000_0006, 64'hBEEF, 64'h0, 0, 0);
    xact(0, 2'd2, 0, 64'h8000_0002, 64'h0, 64'h0, 0, 0);
    xact(0, 2'd3, 0, 64'h8000_0008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 5, 3);
    xact(1, 2'd3, 0, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 5, 3);

    // Timeout: four WAIT cycles without read data, then an error response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_mem_req_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_resp_valid", resp_valid, 0);
      @(negedge clk);
    end
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_rdata", resp_rdata, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_resp_valid", resp_valid, 0);
    chk("late_req_ready", req_ready, 1);
    xact(0, 2'd1, 1, 64'h8000_0022, 64'h0, 64'h0000_0000_F00D_0000, 0, 0);

    // Randomized traffic on the 64-bit unit
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // 32-bit unit: doubleword is illegal, LW is returned unextended
    sel32 = 1'b1;
    xact(0, 2'd3, 0, 64'h0000_0100, 64'h0, 64'h0, 0, 0);
    xact(0, 2'd2, 0, 64'h0000_0104, 64'h0, 64'h8000_1234, 0, 0);
    xact(0, 2'd2, 1, 64'h0000_0108, 64'h0, 64'h8000_1234, 0, 1);
    xact(0, 2'd0, 0, 64'h0000_0103, 64'h0, 64'hA1B2_C3D4, 1, 0);

    // Asynchronous reset during WAIT abandons the load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 64'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("arst_stray_resp_valid", resp_valid, 0);
    chk("arst_req_ready", req_ready, 1);

    // Randomized traffic on the 32-bit unit
    for (int n = 0; n < 20; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {32'h0, $urandom};
      if ($urandom_range(0, 7) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
